// File: rtl/mc_scoreboard_hazard_if.sv
// ID-stage request and scoreboard response bundle for the multi-cycle hazard unit.
// The slave side is the scoreboard. The master side is the pipeline (or the bench).
interface mc_scoreboard_hazard_if #(
  parameter int NREG = 32,
  parameter int RW   = 5,
  parameter int NFU  = 2,
  parameter int FUW  = 1
);
  logic              iFlush;
  logic              iHold;
  logic              iID_Valid;
  logic [RW-1:0]     iID_Rs1;
  logic [RW-1:0]     iID_Rs2;
  logic [RW-1:0]     iID_Rd;
  logic              iID_UseRs1;
  logic              iID_UseRs2;
  logic              iID_WrRd;
  logic              iID_MC;
  logic [FUW-1:0]    iID_FU;
  logic              oIF_Stall;
  logic              oID_Stall;
  logic              oIDEX_Flush;
  logic              oIssue;
  logic [NFU-1:0]    oFU_Busy;
  logic [NFU-1:0]    oCmpl_Valid;
  logic [NFU*RW-1:0] oCmpl_Rd;
  logic [NREG-1:0]   oPending;

  modport slave (
    input  iFlush, iHold, iID_Valid, iID_Rs1, iID_Rs2, iID_Rd,
           iID_UseRs1, iID_UseRs2, iID_WrRd, iID_MC, iID_FU,
    output oIF_Stall, oID_Stall, oIDEX_Flush, oIssue, oFU_Busy,
           oCmpl_Valid, oCmpl_Rd, oPending
  );

  modport master (
    output iFlush, iHold, iID_Valid, iID_Rs1, iID_Rs2, iID_Rd,
           iID_UseRs1, iID_UseRs2, iID_WrRd, iID_MC, iID_FU,
    input  oIF_Stall, oID_Stall, oIDEX_Flush, oIssue, oFU_Busy,
           oCmpl_Valid, oCmpl_Rd, oPending
  );
endinterface

// File: rtl/mc_scoreboard_hazard.sv
// Register scoreboard for non-pipelined multi-cycle FUs. It issues or stalls ID,
// detects RAW/WAW/structural hazards against in-flight results, and pulses completions.
module mc_scoreboard_hazard #(
  parameter int NREG = 32,
  parameter int RW   = 5,
  parameter int NFU  = 2,
  parameter int FUW  = 1,
  parameter int LW   = 6,
  parameter logic [NFU*LW-1:0] FU_LAT = {6'd4, 6'd7}
) (
  input logic iCLK,
  input logic iRST_n,
  mc_scoreboard_hazard_if.slave sb
);

  localparam int NSEL = 1 << FUW;
  localparam logic [LW-1:0]   CNT_IDLE  = {LW{1'b0}};
  localparam logic [LW-1:0]   CNT_LAST  = LW'(1);
  localparam logic [NSEL-1:0] FU_EXIST  = NSEL'((64'd1 << NFU) - 64'd1);

  logic [LW-1:0]   cnt_r      [NFU];
  logic [RW-1:0]   storedRd_r [NFU];
  logic [NFU-1:0]  storedWr_r;
  logic [NREG-1:0] pending_r;

  logic [NFU-1:0]    busy_s;
  logic [NFU-1:0]    cmplValid_s;
  logic [NFU*RW-1:0] cmplRd_s;
  logic [NSEL-1:0]   busySel_s;
  logic [NSEL-1:0]   cmplSel_s;
  logic [NREG-1:0]   clrMask_s;
  logic [NREG-1:0]   setMask_s;
  logic [NREG-1:0]   eff_s;
  logic              rawHaz_s;
  logic              wawHaz_s;
  logic              structHaz_s;
  logic              hazard_s;
  logic              stall_s;
  logic              issue_s;

  // Per-FU status decode and the mask of registers being released this cycle
  always_comb begin
    busy_s      = {NFU{1'b0}};
    cmplValid_s = {NFU{1'b0}};
    cmplRd_s    = {(NFU*RW){1'b0}};
    busySel_s   = {NSEL{1'b0}};
    cmplSel_s   = {NSEL{1'b0}};
    clrMask_s   = {NREG{1'b0}};
    for (int i = 0; i < NFU; i++) begin
      busy_s[i]      = (cnt_r[i] != CNT_IDLE);
      cmplValid_s[i] = (cnt_r[i] == CNT_LAST);
      busySel_s[i]   = busy_s[i];
      cmplSel_s[i]   = cmplValid_s[i];
      if (cmplValid_s[i]) begin
        cmplRd_s[i*RW +: RW] = storedRd_r[i];
      end else begin
        cmplRd_s[i*RW +: RW] = {RW{1'b0}};
      end
      // Ops that never write Rd must not release a register owned by another FU
      if (cmplValid_s[i] && storedWr_r[i]) begin
        clrMask_s[storedRd_r[i]] = 1'b1;
      end else begin
        clrMask_s = clrMask_s;
      end
    end
  end

  // Hazard detection against effective pending, and the issue decision
  always_comb begin
    eff_s       = pending_r & ~clrMask_s;
    eff_s[0]    = 1'b0;
    rawHaz_s    = (sb.iID_UseRs1 && eff_s[sb.iID_Rs1]) ||
                  (sb.iID_UseRs2 && eff_s[sb.iID_Rs2]);
    wawHaz_s    = sb.iID_WrRd && (sb.iID_Rd != {RW{1'b0}}) && eff_s[sb.iID_Rd];
    structHaz_s = sb.iID_MC && busySel_s[sb.iID_FU] && !cmplSel_s[sb.iID_FU];
    hazard_s    = sb.iID_Valid && (rawHaz_s || wawHaz_s || structHaz_s);
    stall_s     = iRST_n && !sb.iFlush && hazard_s;
    issue_s     = iRST_n && sb.iID_Valid && sb.iID_MC && FU_EXIST[sb.iID_FU] &&
                  !hazard_s && !sb.iHold && !sb.iFlush;
    setMask_s   = {NREG{1'b0}};
    if (issue_s && sb.iID_WrRd && (sb.iID_Rd != {RW{1'b0}})) begin
      setMask_s[sb.iID_Rd] = 1'b1;
    end else begin
      setMask_s = {NREG{1'b0}};
    end
  end

  // FU latency counters; a reload on the completion cycle takes priority over the decrement
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < NFU; i++) begin
        cnt_r[i]      <= CNT_IDLE;
        storedRd_r[i] <= {RW{1'b0}};
      end
      storedWr_r <= {NFU{1'b0}};
    end else if (sb.iFlush) begin
      for (int i = 0; i < NFU; i++) begin
        cnt_r[i] <= CNT_IDLE;
      end
      storedWr_r <= {NFU{1'b0}};
    end else begin
      for (int i = 0; i < NFU; i++) begin
        if (issue_s && (sb.iID_FU == FUW'(i))) begin
          cnt_r[i]      <= FU_LAT[i*LW +: LW];
          storedRd_r[i] <= sb.iID_Rd;
          storedWr_r[i] <= sb.iID_WrRd;
        end else if (busy_s[i]) begin
          cnt_r[i] <= cnt_r[i] - CNT_LAST;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Pending bitmap; a set of the same register on the same cycle overrides a release
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pending_r <= {NREG{1'b0}};
    end else if (sb.iFlush) begin
      pending_r <= {NREG{1'b0}};
    end else begin
      pending_r <= (pending_r & ~clrMask_s) | setMask_s;
    end
  end

  assign sb.oIF_Stall   = stall_s;
  assign sb.oID_Stall   = stall_s;
  assign sb.oIDEX_Flush = stall_s;
  assign sb.oIssue      = issue_s;
  assign sb.oFU_Busy    = busy_s;
  assign sb.oCmpl_Valid = cmplValid_s;
  assign sb.oCmpl_Rd    = cmplRd_s;
  assign sb.oPending    = pending_r;

endmodule

// File: tb/tb_mc_scoreboard_hazard.sv
// Directed bench for mc_scoreboard_hazard. A time-based model (issue cycle and latency per FU)
// is compared against the DUT every cycle, and pinned by hand-computed literal checks.
module tb_mc_scoreboard_hazard;

  logic iCLK;
  logic iRST_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  localparam int LAT [2] = '{7, 4};

  mc_scoreboard_hazard_if #(.NREG(32), .RW(5), .NFU(2), .FUW(1)) sbIf ();

  mc_scoreboard_hazard dut (
    .iCLK  (iCLK),
    .iRST_n(iRST_n),
    .sb    (sbIf.slave)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Model state: each FU remembers when its op was accepted and when it is due
  bit       mAct  [2];
  int       mIss  [2];
  int       mDone [2];
  bit [4:0] mRd   [2];
  bit       mWr   [2];

  logic [1:0]  mBusy, mCmpl;
  logic [9:0]  mCmplRd;
  logic [31:0] mPend, mEff;
  logic        mHaz, mStall, mIssue;

  always_comb begin
    mBusy = 2'b00; mCmpl = 2'b00; mCmplRd = 10'd0; mPend = 32'd0; mEff = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (mAct[i] && cyc > mIss[i] && cyc <= mDone[i]) begin
        mBusy[i] = 1'b1;
        if (mWr[i] && mRd[i] != 5'd0) begin
          mPend[mRd[i]] = 1'b1;
          if (cyc < mDone[i]) mEff[mRd[i]] = 1'b1;
        end
        if (cyc == mDone[i]) begin
          mCmpl[i] = 1'b1;
          mCmplRd[i*5 +: 5] = mRd[i];
        end
      end
    end
    mHaz = sbIf.iID_Valid &&
           ((sbIf.iID_UseRs1 && mEff[sbIf.iID_Rs1]) ||
            (sbIf.iID_UseRs2 && mEff[sbIf.iID_Rs2]) ||
            (sbIf.iID_WrRd && sbIf.iID_Rd != 5'd0 && mEff[sbIf.iID_Rd]) ||
            (sbIf.iID_MC && mBusy[sbIf.iID_FU] && !mCmpl[sbIf.iID_FU]));
    mStall = iRST_n && !sbIf.iFlush && mHaz;
    mIssue = iRST_n && sbIf.iID_Valid && sbIf.iID_MC && !mHaz && !sbIf.iHold && !sbIf.iFlush;
  end

  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      mAct[0] <= 1'b0;
      mAct[1] <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (sbIf.iFlush) begin
        mAct[0] <= 1'b0;
        mAct[1] <= 1'b0;
      end else if (mIssue) begin
        mAct[sbIf.iID_FU]  <= 1'b1;
        mIss[sbIf.iID_FU]  <= cyc;
        mDone[sbIf.iID_FU] <= cyc + LAT[sbIf.iID_FU];
        mRd[sbIf.iID_FU]   <= sbIf.iID_Rd;
        mWr[sbIf.iID_FU]   <= sbIf.iID_WrRd;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge iCLK) begin
    chk("if_stall",   {63'd0, sbIf.oIF_Stall},   {63'd0, mStall});
    chk("id_stall",   {63'd0, sbIf.oID_Stall},   {63'd0, mStall});
    chk("idex_flush", {63'd0, sbIf.oIDEX_Flush}, {63'd0, mStall});
    chk("issue",      {63'd0, sbIf.oIssue},      {63'd0, mIssue});
    chk("fu_busy",    {62'd0, sbIf.oFU_Busy},    {62'd0, mBusy});
    chk("cmpl_valid", {62'd0, sbIf.oCmpl_Valid}, {62'd0, mCmpl});
    chk("cmpl_rd",    {54'd0, sbIf.oCmpl_Rd},    {54'd0, mCmplRd});
    chk("pending",    {32'd0, sbIf.oPending},    {32'd0, mPend});
  end

  task automatic setOp(input bit mc, input bit fu, input int rd, input int rs1, input int rs2,
                       input bit u1, input bit u2, input bit wr);
    sbIf.iID_Valid  = 1'b1;
    sbIf.iID_MC     = mc;
    sbIf.iID_FU     = fu;
    sbIf.iID_Rd     = 5'(rd);
    sbIf.iID_Rs1    = 5'(rs1);
    sbIf.iID_Rs2    = 5'(rs2);
    sbIf.iID_UseRs1 = u1;
    sbIf.iID_UseRs2 = u2;
    sbIf.iID_WrRd   = wr;
  endtask

  task automatic mcOp(input bit fu, input int rd, input int rs1, input int rs2);
    setOp(1'b1, fu, rd, rs1, rs2, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic idle();
    setOp(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    sbIf.iID_Valid = 1'b0;
  endtask

  task automatic nxt(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  initial begin
    iRST_n = 1'b0;
    sbIf.iFlush = 1'b0;
    sbIf.iHold  = 1'b0;
    mcOp(1'b0, 5, 6, 7);
    #1;
    chk("rst_issue", {63'd0, sbIf.oIssue}, 64'd0);
    nxt(2);
    chk("rst_busy", {62'd0, sbIf.oFU_Busy}, 64'd0);
    chk("rst_pending", {32'd0, sbIf.oPending}, 64'd0);
    idle();
    #2 iRST_n = 1'b1;
    nxt(1);

    // RAW: DIVREM x5 <- x6/x7, then add x8 <- x5
    mcOp(1'b0, 5, 6, 7); #1;
    chk("raw_issue", {63'd0, sbIf.oIssue}, 64'd1);
    nxt(1);
    setOp(1'b0, 1'b0, 8, 5, 0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      #1 chk("raw_stall", {63'd0, sbIf.oID_Stall}, 64'd1);
      nxt(1);
    end
    #1;
    chk("raw_cmpl", {62'd0, sbIf.oCmpl_Valid}, 64'd1);
    chk("raw_cmpl_rd", {59'd0, sbIf.oCmpl_Rd[4:0]}, 64'd5);
    chk("raw_release", {63'd0, sbIf.oID_Stall}, 64'd0);
    nxt(1);
    idle(); #1;
    chk("raw_pend_clr", {32'd0, sbIf.oPending}, 64'd0);
    nxt(1);

    // Structural: two FU1 ops, second reloads on the first's completion cycle
    mcOp(1'b1, 10, 1, 2); nxt(1);
    mcOp(1'b1, 11, 3, 4);
    for (int k = 1; k <= 3; k++) begin
      #1 chk("struct_stall", {63'd0, sbIf.oIF_Stall}, 64'd1);
      nxt(1);
    end
    #1;
    chk("struct_cmpl_a", {62'd0, sbIf.oCmpl_Valid}, 64'd2);
    chk("struct_rd_a", {59'd0, sbIf.oCmpl_Rd[9:5]}, 64'd10);
    chk("struct_reload", {63'd0, sbIf.oIssue}, 64'd1);
    nxt(1);
    idle(); nxt(3); #1;
    chk("struct_cmpl_b", {62'd0, sbIf.oCmpl_Valid}, 64'd2);
    chk("struct_rd_b", {59'd0, sbIf.oCmpl_Rd[9:5]}, 64'd11);
    nxt(1);

    // Parallel completion: FU0 at cycle 0, FU1 at cycle 3
    mcOp(1'b0, 12, 1, 2); nxt(1);
    idle(); nxt(2);
    mcOp(1'b1, 13, 3, 4); nxt(1);
    idle(); nxt(3); #1;
    chk("par_cmpl", {62'd0, sbIf.oCmpl_Valid}, 64'd3);
    chk("par_rds", {54'd0, sbIf.oCmpl_Rd}, {54'd0, 5'd13, 5'd12});
    nxt(1);
    chk("par_pend_clr", {32'd0, sbIf.oPending}, 64'd0);

    // WAW on x9, then an FU op targeting x0
    mcOp(1'b0, 9, 1, 2); nxt(1);
    setOp(1'b0, 1'b0, 9, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      #1 chk("waw_stall", {63'd0, sbIf.oID_Stall}, 64'd1);
      nxt(1);
    end
    #1 chk("waw_release", {63'd0, sbIf.oID_Stall}, 64'd0);
    nxt(1);
    mcOp(1'b1, 0, 1, 2); nxt(1);
    setOp(1'b0, 1'b0, 3, 0, 0, 1'b1, 1'b0, 1'b1); #1;
    chk("x0_pending", {32'd0, sbIf.oPending}, 64'd0);
    chk("x0_no_stall", {63'd0, sbIf.oID_Stall}, 64'd0);
    nxt(1);
    idle(); nxt(4);

    // Flush at cycle 3 of an FU0 op, with a dependent MC op in ID
    mcOp(1'b0, 14, 1, 2); nxt(1);
    idle(); nxt(2);
    sbIf.iFlush = 1'b1;
    setOp(1'b1, 1'b1, 20, 14, 0, 1'b1, 1'b0, 1'b1); #1;
    chk("flush_stall", {63'd0, sbIf.oID_Stall}, 64'd0);
    chk("flush_issue", {63'd0, sbIf.oIssue}, 64'd0);
    nxt(1);
    sbIf.iFlush = 1'b0;
    idle(); #1;
    chk("flush_busy", {62'd0, sbIf.oFU_Busy}, 64'd0);
    chk("flush_pend", {32'd0, sbIf.oPending}, 64'd0);
    nxt(3);
    chk("flush_no_cmpl", {62'd0, sbIf.oCmpl_Valid}, 64'd0);
    nxt(1);

    // Hold blocks issue but not completion
    mcOp(1'b1, 21, 1, 2); nxt(1);
    sbIf.iHold = 1'b1;
    mcOp(1'b0, 22, 3, 4); #1;
    chk("hold_no_issue", {63'd0, sbIf.oIssue}, 64'd0);
    chk("hold_no_stall", {63'd0, sbIf.oID_Stall}, 64'd0);
    nxt(3);
    chk("hold_cmpl", {62'd0, sbIf.oCmpl_Valid}, 64'd2);
    chk("hold_cmpl_rd", {59'd0, sbIf.oCmpl_Rd[9:5]}, 64'd21);
    nxt(1);
    sbIf.iHold = 1'b0; #1;
    chk("hold_release", {63'd0, sbIf.oIssue}, 64'd1);
    nxt(1);
    idle(); nxt(7);

    // Asynchronous reset at cycle 2 of an in-flight op
    mcOp(1'b0, 15, 1, 2); nxt(1);
    idle(); nxt(1);
    mcOp(1'b1, 16, 3, 4);
    #1 iRST_n = 1'b0;
    #1;
    chk("arst_busy", {62'd0, sbIf.oFU_Busy}, 64'd0);
    chk("arst_pend", {32'd0, sbIf.oPending}, 64'd0);
    chk("arst_issue", {63'd0, sbIf.oIssue}, 64'd0);
    chk("arst_cmpl", {62'd0, sbIf.oCmpl_Valid}, 64'd0);
    nxt(1);
    idle();
    #2 iRST_n = 1'b1;
    nxt(1);
    mcOp(1'b0, 17, 1, 2); #1;
    chk("post_rst_issue", {63'd0, sbIf.oIssue}, 64'd1);
    nxt(1);
    idle(); nxt(6);
    chk("post_rst_cmpl", {62'd0, sbIf.oCmpl_Valid}, 64'd1);
    chk("post_rst_rd", {59'd0, sbIf.oCmpl_Rd[4:0]}, 64'd17);
    nxt(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
